ram_req_ctrl: RTL and testbench

RAM_REQ_CTRL -- requirements
Module: ram_req_ctrl

---
 rtl/ram_req_ctrl_pkg.sv | 17 +
 rtl/ram_req_ctrl_sat_cnt16.sv | 17 +
 rtl/ram_req_ctrl.sv | 154 +++++++++++++++
 tb/tb_ram_req_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_req_ctrl_pkg.sv
// Shared types and default geometry for the RAM request controller.
package ram_req_ctrl_pkg;

    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_AW    = 4;
    localparam int DEFAULT_DW    = 32;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RD_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/ram_req_ctrl_sat_cnt16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_cnt16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/ram_req_ctrl.sv
// Single-outstanding host-to-RAM request controller with post-reset scrub,
// range checking and saturating transaction counters.
module ram_req_ctrl
    import ram_req_ctrl_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW,
    parameter int DW    = DEFAULT_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          mem_wr_enb,
    output logic          mem_rd_enb,
    output logic [AW-1:0] mem_wr_addr,
    output logic [AW-1:0] mem_rd_addr,
    output logic [DW-1:0] mem_data_in,
    input  logic [DW-1:0] mem_data_out,
    output logic          init_done,
    output logic [15:0]   wr_count,
    output logic [15:0]   rd_count,
    output logic [15:0]   err_count
);

    // One extra bit so DEPTH == 2**AW still compares correctly.
    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] INIT_LAST = AW'(DEPTH - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] init_cnt;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          req_write;
    logic          addr_oob;
    logic          cmd_hs;
    logic          rsp_hs;

    assign addr_oob = ({1'b0, cmd_addr} >= DEPTH_W);
    assign cmd_hs   = cmd_valid && (state == ST_IDLE);
    assign rsp_hs   = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + AW'(1);
            end
            // Response fields are cleared at accept so writes/errors report zero data.
            if (cmd_hs) begin
                req_addr  <= cmd_addr;
                req_wdata <= cmd_wdata;
                req_write <= cmd_write;
                rsp_rdata <= '0;
                rsp_err   <= addr_oob;
            end
            if (state == ST_RD_WAIT) begin
                rsp_rdata <= mem_data_out;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        init_done   = 1'b1;
        mem_wr_enb  = 1'b0;
        mem_rd_enb  = 1'b0;
        mem_wr_addr = req_addr;
        mem_rd_addr = req_addr;
        mem_data_in = req_wdata;
        case (state)
            ST_INIT: begin
                init_done   = 1'b0;
                mem_wr_enb  = 1'b1;
                mem_wr_addr = init_cnt;
                mem_data_in = '0;
                if (init_cnt == INIT_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (addr_oob) begin
                        state_nxt = ST_RESP;
                    end else if (cmd_write) begin
                        state_nxt = ST_WR;
                    end else begin
                        state_nxt = ST_RD;
                    end
                end
            end
            ST_WR: begin
                mem_wr_enb = 1'b1;
                state_nxt  = ST_RESP;
            end
            ST_RD: begin
                mem_rd_enb = 1'b1;
                state_nxt  = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    sat_cnt16 u_wr_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (rsp_hs && !rsp_err && req_write),
        .count (wr_count)
    );

    sat_cnt16 u_rd_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (rsp_hs && !rsp_err && !req_write),
        .count (rd_count)
    );

    sat_cnt16 u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (rsp_hs && rsp_err),
        .count (err_count)
    );

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Directed bench for ram_req_ctrl with a registered-read RAM model attached.
module tb_ram_req_ctrl;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_wr_enb;
    logic        mem_rd_enb;
    logic [3:0]  mem_wr_addr;
    logic [3:0]  mem_rd_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        init_done;
    logic [15:0] wr_count;
    logic [15:0] rd_count;
    logic [15:0] err_count;

    int errors = 0;
    int checks = 0;

    logic [31:0] ram [0:15];
    logic        preload;

    ram_req_ctrl #(
        .DEPTH (8),
        .AW    (4),
        .DW    (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_wr_enb   (mem_wr_enb),
        .mem_rd_enb   (mem_rd_enb),
        .mem_wr_addr  (mem_wr_addr),
        .mem_rd_addr  (mem_rd_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .init_done    (init_done),
        .wr_count     (wr_count),
        .rd_count     (rd_count),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Nonzero preload makes the scrub visible on later reads.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) ram[i] <= 32'hA5A5_0000 | 32'(i);
        end else if (mem_wr_enb) begin
            ram[mem_wr_addr] <= mem_data_in;
        end
        if (mem_rd_enb) mem_data_out <= ram[mem_rd_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic w, input logic [3:0] a, input logic [31:0] d);
        chk("cmd_ready_before_send", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
    endtask

    task automatic check_scrub();
        for (int i = 0; i < 8; i++) begin
            chk("scrub_wr_enb", {31'b0, mem_wr_enb}, 32'd1);
            chk("scrub_wr_addr", {28'b0, mem_wr_addr}, 32'(i));
            chk("scrub_data", mem_data_in, 32'd0);
            chk("scrub_init_done", {31'b0, init_done}, 32'd0);
            chk("scrub_cmd_ready", {31'b0, cmd_ready}, 32'd0);
            chk("scrub_rsp_valid", {31'b0, rsp_valid}, 32'd0);
            tick();
        end
        chk("init_done_after_scrub", {31'b0, init_done}, 32'd1);
        chk("cmd_ready_after_scrub", {31'b0, cmd_ready}, 32'd1);
        chk("wr_enb_after_scrub", {31'b0, mem_wr_enb}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        preload   = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        tick();
        preload = 1'b0;
        tick();

        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        chk("rst_init_done", {31'b0, init_done}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_counts", {wr_count[7:0], rd_count[7:0], err_count[7:0], 8'h0}, 32'd0);

        // Commands presented during the scrub must be ignored.
        rst       = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 4'd2;
        cmd_wdata = 32'h1111_2222;
        check_scrub();
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;

        // Read of scrubbed location 5
        send(1'b0, 4'd5, 32'd0);
        chk("rd5_rd_enb", {31'b0, mem_rd_enb}, 32'd1);
        chk("rd5_rd_addr", {28'b0, mem_rd_addr}, 32'd5);
        chk("rd5_wr_enb", {31'b0, mem_wr_enb}, 32'd0);
        chk("rd5_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        tick();
        chk("rd5_wait_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rd5_wait_rd_enb", {31'b0, mem_rd_enb}, 32'd0);
        tick();
        chk("rd5_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("rd5_rdata", rsp_rdata, 32'd0);
        chk("rd5_err", {31'b0, rsp_err}, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rd5_rsp_dropped", {31'b0, rsp_valid}, 32'd0);
        chk("rd5_rd_count", {16'b0, rd_count}, 32'd1);

        // Write addr 3
        send(1'b1, 4'd3, 32'hDEAD_BEEF);
        chk("wr3_wr_enb", {31'b0, mem_wr_enb}, 32'd1);
        chk("wr3_wr_addr", {28'b0, mem_wr_addr}, 32'd3);
        chk("wr3_data", mem_data_in, 32'hDEAD_BEEF);
        chk("wr3_rd_enb", {31'b0, mem_rd_enb}, 32'd0);
        chk("wr3_no_rsp_yet", {31'b0, rsp_valid}, 32'd0);
        tick();
        chk("wr3_wr_enb_once", {31'b0, mem_wr_enb}, 32'd0);
        chk("wr3_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("wr3_rdata", rsp_rdata, 32'd0);
        chk("wr3_err", {31'b0, rsp_err}, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("wr3_wr_count", {16'b0, wr_count}, 32'd1);

        // Read addr 3, then stall the response
        send(1'b0, 4'd3, 32'd0);
        tick();
        chk("rd3_no_rsp_early", {31'b0, rsp_valid}, 32'd0);
        tick();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 4'd0;
        cmd_wdata = 32'h0000_1234;
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("stall_rdata", rsp_rdata, 32'hDEAD_BEEF);
            chk("stall_err", {31'b0, rsp_err}, 32'd0);
            chk("stall_cmd_ready", {31'b0, cmd_ready}, 32'd0);
            chk("stall_wr_enb", {31'b0, mem_wr_enb}, 32'd0);
            tick();
        end
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rd3_rd_count", {16'b0, rd_count}, 32'd2);
        chk("rd3_wr_count", {16'b0, wr_count}, 32'd1);

        // Out-of-range read addr 9
        send(1'b0, 4'd9, 32'd0);
        chk("oob9_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("oob9_err", {31'b0, rsp_err}, 32'd1);
        chk("oob9_rdata", rsp_rdata, 32'd0);
        chk("oob9_rd_enb", {31'b0, mem_rd_enb}, 32'd0);
        chk("oob9_wr_enb", {31'b0, mem_wr_enb}, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("oob9_err_count", {16'b0, err_count}, 32'd1);
        chk("oob9_rd_count", {16'b0, rd_count}, 32'd2);

        // Write to addr 8 (== DEPTH) is also an error
        send(1'b1, 4'd8, 32'hCAFE_F00D);
        chk("oob8_wr_enb", {31'b0, mem_wr_enb}, 32'd0);
        chk("oob8_err", {31'b0, rsp_err}, 32'd1);
        chk("oob8_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("oob8_err_count", {16'b0, err_count}, 32'd2);
        chk("oob8_wr_count", {16'b0, wr_count}, 32'd1);

        // Reset in RD_WAIT abandons the read
        send(1'b0, 4'd3, 32'd0);
        tick();
        rst       = 1'b1;
        rsp_ready = 1'b1;
        tick();
        chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("midrst_init_done", {31'b0, init_done}, 32'd0);
        chk("midrst_rdata", rsp_rdata, 32'd0);
        chk("midrst_wr_count", {16'b0, wr_count}, 32'd0);
        chk("midrst_rd_count", {16'b0, rd_count}, 32'd0);
        chk("midrst_err_count", {16'b0, err_count}, 32'd0);
        rst       = 1'b0;
        rsp_ready = 1'b0;
        check_scrub();

        // Location 3 must be scrubbed again
        send(1'b0, 4'd3, 32'd0);
        tick();
        tick();
        chk("rescrub_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("rescrub_rdata", rsp_rdata, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rescrub_rd_count", {16'b0, rd_count}, 32'd1);
        chk("rescrub_err_count", {16'b0, err_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
